tensor_cfg_dispatcher: RTL and testbench
========================================

Name: tensor_cfg_dispatcher

Overview:
Multi-channel successor to the single-output tensor config controller. It accepts packed tensor-op config words on one AXI-stream slave and buffers them in an input FIFO. Each word is decoded and checked: the operator field is stripped and the remaining descriptor is routed to one of NUM_CH engine channels (bitcast, transpose, reshape, ...), each with its own AXI-stream master. Illegal configs are dropped and reported. The block sits between the host config path and the tensor engines.

Parameters:
NUM_CH, 4, number of engine output channels (1..31)
RANK, 4, dimensions per tensor
DIM_W, 10, bits per dimension element
ADDR_W, 11, src/dstn address width
SZ_W, 3, in_size/out_size width
MAX_SIZE, 4, largest legal in_size/out_size code
IN_DEPTH, 8, input FIFO depth (power of 2, >=2)
CNT_W, 16, status counter width
Derived (localparam): CFG_W = 10+2*RANK*DIM_W+2*ADDR_W+2*SZ_W (118 default); DESC_W = CFG_W-5 (113 default)

Ports:
clock  in  1  system clock
reset_n  in  1  reset
cfg_in_tdata  in  CFG_W  packed config, MSB-first: operator[5], sub_op[5], src_dim, dstn_dim, src_addr, dstn_addr, in_size, out_size
cfg_in_tvalid  in  1  config valid
cfg_in_tready  out  1  config ready
desc_out_tdata  out  NUM_CH*DESC_W  channel c at [c*DESC_W +: DESC_W]; the config word with the operator field removed
desc_out_tvalid  out  NUM_CH  per-channel valid
desc_out_tready  in  NUM_CH  per-channel ready
err_valid  out  1  one-cycle pulse per dropped illegal config
err_code  out  2  1=zero dim, 2=size over MAX_SIZE, 3=bad operator; held until next error
err_cnt  out  CNT_W  illegal configs dropped, saturating
nop_cnt  out  CNT_W  NOP configs dropped, saturating

Behaviour:
- Reset: reset_n, synchronous, active-low; clock clock. Reset clears the FIFO, FSM, channel slots and counters. All outputs are 0 in reset, except desc_out_tdata, which is don't-care. Reset mid-operation discards all in-flight configs with no error reported.
- Dimension element i sits at dim[i*DIM_W +: DIM_W].
- Input: cfg_in_tready = !fifo_full. There is no bypass when full: a same-cycle pop does not raise tready. The transfer occurs on tvalid&&tready at a rising edge.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the decode register at the next edge and go to CHECK.
  - CHECK: classify the word, in priority order:
    - operator==0: NOP.
    - operator>NUM_CH: err 3.
    - any src/dstn dim element ==0: err 1.
    - in_size or out_size >MAX_SIZE: err 2.
    - otherwise: target channel ch=operator-1.
  - DISPATCH: if slot ch is empty, or is emptying this cycle (valid&&ready), load the descriptor at the edge and go to IDLE. Otherwise wait in DISPATCH (head-of-line blocking, intended). A pop from the FIFO may occur in the same edge as the dispatch load.
  - DROP (NOP/error): one cycle. Pulse err_valid, update err_code, increment the counter, return to IDLE.
- Latency: a word accepted at edge E0 with its channel free has desc_out_tvalid high after edge E0+3 (FIFO, decode, slot). Sustained throughput is one config per 2 clocks.
- Channel slot: tvalid stays high and tdata stays stable until tready. The slot clears at the edge where valid&&ready holds. Channels drain independently.
- Ordering: descriptors to the same channel leave in arrival order. Cross-channel order is arrival order at dispatch only.
- FIFO: count-based full/empty, pointers wrap at IN_DEPTH. A simultaneous push and pop keeps the count unchanged.
- Counters saturate at all-ones.

Decomposition:
- Package tensor_cfg_pkg holds:
  - the parametrised field-width localparams, CFG_W/DESC_W;
  - the err_code enum (ERR_NONE, ERR_ZERO_DIM, ERR_SIZE, ERR_OP);
  - the FSM state enum;
  - field-extract functions (get_operator, get_dim, strip_operator).
- One sub-module: tensor_cfg_fifo (synchronous FIFO, WIDTH/DEPTH parameters, full/empty/count).

Test Plan:
- Defaults, NUM_CH=4, all tready=1. Send operator=2, dims {2,3,4,5}/{5,4,3,2}, src_addr=16, dstn_addr=64, sizes 2/2 -> channel 1 tvalid after E0+3, tdata equals input[112:0], other channels idle.
- Send operator=0, then operator=7 -> no tvalid on any channel, nop_cnt=1, err_valid pulses once with err_code=3, err_cnt=1.
- Send operator=1 with src_dim element 2 =0 and in_size=6 -> err_code=1 (priority over size), err_cnt=1. Next send in_size=5, dims nonzero -> err_code=2.
- Hold desc_out_tready[0]=0, stream 10 configs to channel 0 back-to-back -> tready low once FIFO holds 8 plus the decode word. Release ready -> all 10 emerge in order, none lost.
- Alternate configs to channels 2 and 3 while channel 2's tready toggles every cycle -> per-channel order preserved, each tdata stable while tvalid&&!tready.
- Assert reset_n=0 for 1 cycle with the FIFO holding 5 words and slot 0 valid -> next cycle all tvalid=0, cfg_in_tready=1, counters=0, no err_valid.

Source files
------------

// File: rtl/tensor_cfg_pkg.sv
// Shared types and field helpers for the tensor config dispatcher.
// Config word layout, MSB-first: operator, sub_op, src_dim, dstn_dim,
// src_addr, dstn_addr, in_size, out_size. The descriptor is the word minus operator.
package tensor_cfg_pkg;

  localparam int unsigned OP_W     = 5;
  localparam int unsigned RANK     = 4;
  localparam int unsigned DIM_W    = 10;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned SZ_W     = 3;
  localparam int unsigned MAX_SIZE = 4;
  localparam int unsigned DIMS_W   = RANK * DIM_W;
  localparam int unsigned CFG_W    = 2*OP_W + 2*DIMS_W + 2*ADDR_W + 2*SZ_W;
  localparam int unsigned DESC_W   = CFG_W - OP_W;

  typedef struct packed {
    logic [OP_W-1:0]   op_code;
    logic [OP_W-1:0]   sub_op;
    logic [DIMS_W-1:0] src_dim;
    logic [DIMS_W-1:0] dstn_dim;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dstn_addr;
    logic [SZ_W-1:0]   in_size;
    logic [SZ_W-1:0]   out_size;
  } cfg_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_DIM = 2'd1,
    ERR_SIZE     = 2'd2,
    ERR_OP       = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPATCH,
    ST_DROP
  } state_e;

  function automatic logic [OP_W-1:0] get_operator(input cfg_t cfg);
    return cfg.op_code;
  endfunction

  // Element idx of a dimension vector
  function automatic logic [DIM_W-1:0] get_dim(input logic [DIMS_W-1:0] dims,
                                               input int unsigned idx);
    return dims[idx*DIM_W +: DIM_W];
  endfunction

  function automatic logic [DESC_W-1:0] strip_operator(input cfg_t cfg);
    logic [CFG_W-1:0] raw;
    raw = cfg;
    return raw[DESC_W-1:0];
  endfunction

  function automatic logic has_zero_dim(input logic [DIMS_W-1:0] dims);
    logic zero;
    zero = 1'b0;
    for (int unsigned i = 0; i < RANK; i++) begin
      if (get_dim(dims, i) == '0) zero = 1'b1;
    end
    return zero;
  endfunction

endpackage

// File: rtl/tensor_cfg_if.sv
// Config-in / descriptor-out stream bundle.
// slave: dispatcher side; master: host + engine side.
interface tensor_cfg_if
  import tensor_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) ();

  logic [CFG_W-1:0]         cfg_in_tdata;
  logic                     cfg_in_tvalid;
  logic                     cfg_in_tready;
  logic [NUM_CH*DESC_W-1:0] desc_out_tdata;
  logic [NUM_CH-1:0]        desc_out_tvalid;
  logic [NUM_CH-1:0]        desc_out_tready;

  modport slave (
    input  cfg_in_tdata, cfg_in_tvalid,
    output cfg_in_tready,
    output desc_out_tdata, desc_out_tvalid,
    input  desc_out_tready
  );

  modport master (
    output cfg_in_tdata, cfg_in_tvalid,
    input  cfg_in_tready,
    input  desc_out_tdata, desc_out_tvalid,
    output desc_out_tready
  );

endinterface

// File: rtl/tensor_cfg_fifo.sv
// Synchronous count-based FIFO.
// Ports: clock, reset_n (sync, active-low), push/wdata, pop/rdata (show-ahead), full, empty.
module tensor_cfg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem[rd_ptr_q];

  // Pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tensor_cfg_dispatcher.sv
// Buffers packed tensor-op configs, validates them and routes the
// operator-stripped descriptor to one of NUM_CH engine stream channels.
// Ports: clock, reset_n (sync, active-low); bus (config in / per-channel
// descriptor out streams); err_valid pulse, err_code (held), err_cnt/nop_cnt.
module tensor_cfg_dispatcher
  import tensor_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned IN_DEPTH = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  tensor_cfg_if.slave      bus,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] nop_cnt
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              fifo_full, fifo_empty, fifo_pop, cfg_ready;
  logic [CFG_W-1:0]  fifo_rdata;
  state_e            state_q, state_d;
  cfg_t              dec_q;
  logic [CH_W-1:0]   ch_q;
  logic [OP_W-1:0]   chk_op;
  logic              chk_nop;
  err_code_e         chk_code;
  logic [CH_W-1:0]   chk_ch;
  logic              load;
  logic [NUM_CH-1:0] slot_valid_q, slot_free;
  logic [DESC_W-1:0] slot_data_q [NUM_CH];
  logic              err_valid_q;
  err_code_e         err_code_q;
  logic [CNT_W-1:0]  err_cnt_q, nop_cnt_q;

  // Ready is held low in reset so every output reads 0 there
  assign cfg_ready         = reset_n && !fifo_full;
  assign bus.cfg_in_tready = cfg_ready;

  tensor_cfg_fifo #(
    .WIDTH (CFG_W),
    .DEPTH (IN_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (bus.cfg_in_tvalid && cfg_ready),
    .wdata   (bus.cfg_in_tdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Classification of the decode word, highest priority first
  always_comb begin
    chk_op   = get_operator(dec_q);
    chk_nop  = (chk_op == '0);
    chk_ch   = CH_W'(chk_op - OP_W'(1));
    chk_code = ERR_NONE;
    if (32'(chk_op) > NUM_CH)
      chk_code = ERR_OP;
    else if (has_zero_dim(dec_q.src_dim) || has_zero_dim(dec_q.dstn_dim))
      chk_code = ERR_ZERO_DIM;
    else if (32'(dec_q.in_size) > MAX_SIZE || 32'(dec_q.out_size) > MAX_SIZE)
      chk_code = ERR_SIZE;
  end

  // A slot can take a new descriptor if empty or draining this cycle
  assign slot_free = ~slot_valid_q | bus.desc_out_tready;

  // Next-state; a dispatch may pop the next word on the same edge
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = (!chk_nop && chk_code == ERR_NONE) ? ST_DISPATCH : ST_DROP;
      end
      ST_DISPATCH: begin
        if (slot_free[ch_q]) begin
          load = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, target channel and error/status reporting
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= '0;
      nop_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      err_valid_q <= 1'b0;
      if (state_q == ST_CHECK) begin
        ch_q <= chk_ch;
        if (chk_nop) begin
          if (~&nop_cnt_q) nop_cnt_q <= nop_cnt_q + CNT_W'(1);
        end else if (chk_code != ERR_NONE) begin
          err_valid_q <= 1'b1;
          err_code_q  <= chk_code;
          if (~&err_cnt_q) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Decode register
  always_ff @(posedge clock) begin
    if (fifo_pop) dec_q <= fifo_rdata;
  end

  // Channel slot valids: load wins over a same-edge drain
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_valid_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (load && ch_q == CH_W'(c))
          slot_valid_q[c] <= 1'b1;
        else if (bus.desc_out_tready[c])
          slot_valid_q[c] <= 1'b0;
      end
    end
  end

  // Channel slot payloads
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (load && ch_q == CH_W'(c)) slot_data_q[c] <= strip_operator(dec_q);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.desc_out_tdata[g*DESC_W +: DESC_W] = slot_data_q[g];
  end

  assign bus.desc_out_tvalid = slot_valid_q;
  assign err_valid           = err_valid_q;
  assign err_code            = err_code_q;
  assign err_cnt             = err_cnt_q;
  assign nop_cnt             = nop_cnt_q;

endmodule

// File: tb/tb_tensor_cfg_dispatcher.sv
// Self-checking bench for tensor_cfg_dispatcher: random configs scored
// against a per-channel expected-descriptor model plus directed scenarios.
`timescale 1ns/1ps
module tb_tensor_cfg_dispatcher;
  import tensor_cfg_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned IN_LO   = SZ_W;
  localparam int unsigned DDIM_LO = 2*SZ_W + 2*ADDR_W;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tensor_cfg_if #(.NUM_CH(NCH)) bus ();
  logic          err_valid;
  logic [1:0]    err_code;
  logic [CW-1:0] err_cnt, nop_cnt;

  tensor_cfg_dispatcher #(.NUM_CH(NCH), .IN_DEPTH(8), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_cnt   (err_cnt),
    .nop_cnt   (nop_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DESC_W-1:0] exp_q [NCH][$];
  int exp_err = 0, exp_nop = 0, exp_code = 0;
  int rx_cnt [NCH];
  int err_pulses = 0;

  // Monitor state
  logic [NCH-1:0]    prev_hold = '0;
  logic [DESC_W-1:0] prev_data [NCH];
  logic [DESC_W-1:0] mon_d, mon_e;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard on every channel handshake plus hold stability
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hold = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        mon_d = bus.desc_out_tdata[c*DESC_W +: DESC_W];
        if (prev_hold[c]) begin
          checks++;
          if (bus.desc_out_tvalid[c] !== 1'b1 || mon_d !== prev_data[c]) begin
            failures++;
            $display("FAIL hold_stable ch=%0d valid=%b data=%h required valid=1 data=%h",
                     c, bus.desc_out_tvalid[c], mon_d, prev_data[c]);
          end
        end
        if (bus.desc_out_tvalid[c] === 1'b1 && bus.desc_out_tready[c] === 1'b1) begin
          checks++;
          rx_cnt[c]++;
          if (exp_q[c].size() == 0) begin
            failures++;
            $display("FAIL unexpected_desc ch=%0d got=%h required none", c, mon_d);
          end else begin
            mon_e = exp_q[c].pop_front();
            if (mon_d !== mon_e) begin
              failures++;
              $display("FAIL desc_order ch=%0d got=%h required=%h", c, mon_d, mon_e);
            end
          end
        end
        prev_hold[c] = bus.desc_out_tvalid[c] && !bus.desc_out_tready[c];
        prev_data[c] = mon_d;
      end
      if (err_valid === 1'b1) err_pulses++;
    end
  end

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += exp_q[c].size();
    return n;
  endfunction

  function automatic int rx_total();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += rx_cnt[c];
    return n;
  endfunction

  function automatic logic [DIMS_W-1:0] rand_dims();
    logic [DIMS_W-1:0] d;
    for (int i = 0; i < RANK; i++)
      d[i*DIM_W +: DIM_W] = DIM_W'($urandom_range(1, (1 << DIM_W) - 1));
    return d;
  endfunction

  function automatic logic [CFG_W-1:0] build(input int op, input logic [DIMS_W-1:0] sd,
                                             input logic [DIMS_W-1:0] dd, input int isz,
                                             input int osz);
    return {OP_W'(op), OP_W'($urandom), sd, dd, ADDR_W'($urandom), ADDR_W'($urandom),
            SZ_W'(isz), SZ_W'(osz)};
  endfunction

  function automatic logic [CFG_W-1:0] rand_legal(input int op);
    return build(op, rand_dims(), rand_dims(), $urandom_range(0, MAX_SIZE),
                 $urandom_range(0, MAX_SIZE));
  endfunction

  // Expected outcome of one config, straight from the classification rules
  task automatic model_push(input logic [CFG_W-1:0] w);
    int op, isz, osz;
    bit zero;
    op   = int'(w[CFG_W-1 -: OP_W]);
    isz  = int'(w[IN_LO +: SZ_W]);
    osz  = int'(w[SZ_W-1:0]);
    zero = 1'b0;
    for (int i = 0; i < 2*RANK; i++)
      if (w[DDIM_LO + i*DIM_W +: DIM_W] == '0) zero = 1'b1;
    if (op == 0) exp_nop++;
    else if (op > int'(NCH)) begin exp_err++; exp_code = 3; end
    else if (zero) begin exp_err++; exp_code = 1; end
    else if (isz > int'(MAX_SIZE) || osz > int'(MAX_SIZE)) begin exp_err++; exp_code = 2; end
    else exp_q[op-1].push_back(w[DESC_W-1:0]);
  endtask

  // Drive one word; returns at #1 after its accepting edge
  task automatic send(input logic [CFG_W-1:0] w, output bit ok);
    int n = 0;
    model_push(w);
    bus.cfg_in_tdata  = w;
    bus.cfg_in_tvalid = 1'b1;
    @(negedge clock);
    while (bus.cfg_in_tready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok = (bus.cfg_in_tready === 1'b1);
    @(posedge clock);
    #1;
    bus.cfg_in_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int min_cyc);
    int n = 0;
    repeat (min_cyc) @(posedge clock);
    while ((pending() != 0 || bus.desc_out_tvalid !== '0) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.cfg_in_tvalid   = 1'b0;
    bus.cfg_in_tdata    = '0;
    bus.desc_out_tready = '1;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.desc_out_tvalid !== '0 || bus.cfg_in_tready !== 1'b0 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs tvalid=%b tready=%b err_valid=%b required all 0",
               bus.desc_out_tvalid, bus.cfg_in_tready, err_valid);
    end
    checks++;
    if (err_code !== 2'd0 || err_cnt !== '0 || nop_cnt !== '0) begin
      failures++;
      $display("FAIL reset_status err_code=%0d err_cnt=%0d nop_cnt=%0d required 0",
               err_code, err_cnt, nop_cnt);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.cfg_in_tready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready tready=%b required 1", bus.cfg_in_tready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_latency();
    logic [DIMS_W-1:0] sd, dd;
    logic [CFG_W-1:0]  w;
    logic [DESC_W-1:0] d;
    bit ok;
    for (int i = 0; i < RANK; i++) begin
      sd[i*DIM_W +: DIM_W] = DIM_W'(2 + i);
      dd[i*DIM_W +: DIM_W] = DIM_W'(5 - i);
    end
    w = {OP_W'(2), OP_W'(9), sd, dd, ADDR_W'(16), ADDR_W'(64), SZ_W'(2), SZ_W'(2)};
    d = w[DESC_W-1:0];
    send(w, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL latency_accept accepted=0 required 1"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (bus.desc_out_tvalid !== '0) begin
        failures++;
        $display("FAIL latency_early cycle=%0d tvalid=%b required 0000", k + 1, bus.desc_out_tvalid);
      end
    end
    @(negedge clock);
    checks++;
    if (bus.desc_out_tvalid !== 4'b0010) begin
      failures++;
      $display("FAIL latency_valid tvalid=%b required 0010", bus.desc_out_tvalid);
    end
    checks++;
    if (bus.desc_out_tdata[DESC_W +: DESC_W] !== d) begin
      failures++;
      $display("FAIL latency_data got=%h required=%h", bus.desc_out_tdata[DESC_W +: DESC_W], d);
    end
    wait_idle(4);
  endtask

  task automatic test_drop();
    bit ok0, ok1;
    int rx0;
    rx0 = rx_total();
    send(rand_legal(0), ok0);
    send(rand_legal(7), ok1);
    wait_idle(30);
    checks++;
    if (nop_cnt !== CW'(exp_nop) || err_cnt !== CW'(exp_err)) begin
      failures++;
      $display("FAIL drop_counts nop_cnt=%0d err_cnt=%0d required %0d %0d",
               nop_cnt, err_cnt, exp_nop, exp_err);
    end
    checks++;
    if (err_code !== 2'(exp_code) || err_pulses != exp_err) begin
      failures++;
      $display("FAIL drop_err err_code=%0d pulses=%0d required %0d %0d",
               err_code, err_pulses, exp_code, exp_err);
    end
    checks++;
    if (rx_total() != rx0 || !(ok0 && ok1)) begin
      failures++;
      $display("FAIL drop_no_desc delivered=%0d accepted=%b%b required 0 11",
               rx_total() - rx0, ok0, ok1);
    end
  endtask

  task automatic test_priority();
    logic [DIMS_W-1:0] sd;
    bit ok;
    sd = rand_dims();
    sd[2*DIM_W +: DIM_W] = '0;
    send(build(1, sd, rand_dims(), 6, 1), ok);
    wait_idle(20);
    checks++;
    if (err_code !== 2'd1 || err_cnt !== CW'(exp_err) || exp_code != 1) begin
      failures++;
      $display("FAIL prio_zero_dim err_code=%0d err_cnt=%0d required 1 %0d", err_code, err_cnt, exp_err);
    end
    send(build(1, rand_dims(), rand_dims(), 5, 0), ok);
    wait_idle(20);
    checks++;
    if (err_code !== 2'd2 || err_cnt !== CW'(exp_err) || exp_code != 2) begin
      failures++;
      $display("FAIL prio_size err_code=%0d err_cnt=%0d required 2 %0d", err_code, err_cnt, exp_err);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, rx0;
    bit ok;
    rx0 = rx_cnt[0];
    bus.desc_out_tready[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(rand_legal(1), ok);
      if (ok) acc++;
    end
    @(negedge clock);
    checks++;
    if (bus.cfg_in_tready !== 1'b0 || acc != 10) begin
      failures++;
      $display("FAIL bp_full tready=%b accepted=%0d required 0 10", bus.cfg_in_tready, acc);
    end
    repeat (5) @(posedge clock);
    #1 bus.desc_out_tready[0] = 1'b1;
    wait_idle(5);
    checks++;
    if (pending() != 0 || rx_cnt[0] - rx0 != 10) begin
      failures++;
      $display("FAIL bp_drain pending=%0d delivered=%0d required 0 10", pending(), rx_cnt[0] - rx0);
    end
  endtask

  task automatic test_toggle();
    bit ok;
    fork
      begin
        for (int i = 0; i < 20; i++) send(rand_legal(3 + (i % 2)), ok);
      end
      begin
        repeat (150) begin
          @(posedge clock);
          #1 bus.desc_out_tready[2] = ~bus.desc_out_tready[2];
        end
      end
    join
    bus.desc_out_tready[2] = 1'b1;
    wait_idle(5);
    checks++;
    if (pending() != 0) begin
      failures++;
      $display("FAIL toggle_drain pending=%0d required 0", pending());
    end
  endtask

  task automatic test_random();
    bit done = 1'b0, ok;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [DIMS_W-1:0] sd, dd;
          int isz, idx;
          sd = rand_dims();
          dd = rand_dims();
          idx = $urandom_range(0, RANK - 1);
          if ($urandom_range(0, 5) == 0) sd[idx*DIM_W +: DIM_W] = '0;
          if ($urandom_range(0, 5) == 0) dd[idx*DIM_W +: DIM_W] = '0;
          isz = ($urandom_range(0, 6) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
          send(build($urandom_range(0, NCH + 2), sd, dd, isz, $urandom_range(0, 4)), ok);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1 bus.desc_out_tready = NCH'($urandom);
        end
      end
    join
    bus.desc_out_tready = '1;
    wait_idle(30);
    checks++;
    if (pending() != 0) begin
      failures++;
      $display("FAIL random_drain pending=%0d required 0", pending());
    end
    checks++;
    if (err_cnt !== CW'(exp_err) || nop_cnt !== CW'(exp_nop) || err_pulses != exp_err) begin
      failures++;
      $display("FAIL random_counts err_cnt=%0d nop_cnt=%0d pulses=%0d required %0d %0d %0d",
               err_cnt, nop_cnt, err_pulses, exp_err, exp_nop, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.desc_out_tready[0] = 1'b0;
    for (int i = 0; i < 7; i++) send(rand_legal(1), ok);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    exp_err = 0; exp_nop = 0; exp_code = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    err_pulses = 0;
    @(negedge clock);
    checks++;
    if (bus.desc_out_tvalid !== '0 || bus.cfg_in_tready !== 1'b1 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs tvalid=%b tready=%b err_valid=%b required 0000 1 0",
               bus.desc_out_tvalid, bus.cfg_in_tready, err_valid);
    end
    checks++;
    if (err_cnt !== '0 || nop_cnt !== '0) begin
      failures++;
      $display("FAIL midreset_counts err_cnt=%0d nop_cnt=%0d required 0 0", err_cnt, nop_cnt);
    end
    @(posedge clock);
    #1 bus.desc_out_tready = '1;
    send(rand_legal(1), ok);
    wait_idle(20);
    checks++;
    if (pending() != 0 || err_pulses != 0) begin
      failures++;
      $display("FAIL midreset_recover pending=%0d pulses=%0d required 0 0", pending(), err_pulses);
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) rx_cnt[c] = 0;
    test_reset();
    test_latency();
    test_drop();
    test_priority();
    test_backpressure();
    test_toggle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
